fp_add_sequencer: RTL and testbench

//  Multi-cycle IEEE-754 single-precision add/sub controller. Sequences one shared
//  24-bit mantissa ripple-carry adder (ripple_carry_adder_floating, single instance)

---
 rtl/fp_add_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Multi-cycle single-precision add/sub: one shared 24-bit ripple-carry adder
// sequenced through ALIGN -> ADD -> NORM, with valid/ready handshakes on both sides.

module ripple_carry_adder_floating #(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    logic [W:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[W];
endmodule

module fp_add_sequencer #(
    parameter int MAX_NORM = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int CW = $clog2(MAX_NORM + 1);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t        r_state;
    logic [31:0]   r_a, r_b;
    logic [23:0]   r_big_mant, r_small_mant, r_mant;
    logic [7:0]    r_exp;
    logic          r_sign, r_eff_sub, r_cout;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_out_data;
    logic          r_out_valid, r_in_ready, r_busy;

    // Operand decode and alignment, evaluated from the captured operands
    logic [7:0]  w_a_exp, w_b_exp, w_big_exp, w_small_exp, w_diff;
    logic [23:0] w_a_mant, w_b_mant, w_big_mant, w_small_mant, w_small_shifted;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_ge, w_nan_result;

    assign w_a_exp  = r_a[30:23];
    assign w_b_exp  = r_b[30:23];
    assign w_a_mant = (w_a_exp == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    assign w_b_mant = (w_b_exp == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
    assign w_a_nan  = (w_a_exp == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (w_b_exp == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_a_inf  = (w_a_exp == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (w_b_exp == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_nan_result = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31]));

    assign w_a_ge       = (w_a_exp > w_b_exp) || ((w_a_exp == w_b_exp) && (w_a_mant >= w_b_mant));
    assign w_big_exp    = w_a_ge ? w_a_exp  : w_b_exp;
    assign w_small_exp  = w_a_ge ? w_b_exp  : w_a_exp;
    assign w_big_mant   = w_a_ge ? w_a_mant : w_b_mant;
    assign w_small_mant = w_a_ge ? w_b_mant : w_a_mant;
    assign w_diff       = w_big_exp - w_small_exp;
    assign w_small_shifted = (w_diff >= 8'd24) ? 24'd0 : (w_small_mant >> w_diff);

    // Subtraction is big + ~small + 1; big >= small so the difference never goes negative
    logic [23:0] w_sum;
    logic        w_cout;

    ripple_carry_adder_floating #(.W(24)) u_adder (
        .i_a    (r_big_mant),
        .i_b    (r_eff_sub ? ~r_small_mant : r_small_mant),
        .i_cin  (r_eff_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    logic [23:0] w_norm_mant;
    logic [7:0]  w_norm_exp, w_inc_exp;
    logic        w_norm_done;
    logic [31:0] w_norm_result;

    assign w_norm_mant = {r_mant[22:0], 1'b0};
    assign w_norm_exp  = r_exp - 8'd1;
    assign w_inc_exp   = r_exp + 8'd1;

    always_comb begin
        w_norm_done   = 1'b0;
        w_norm_result = 32'd0;
        if (r_cout) begin
            w_norm_done   = 1'b1;
            w_norm_result = (w_inc_exp == 8'hFF) ? {r_sign, 8'hFF, 23'd0}
                                                 : {r_sign, w_inc_exp, r_mant[23:1]};
        end else if (r_mant == 24'd0) begin
            w_norm_done = 1'b1;
        end else if (r_mant[23]) begin
            w_norm_done   = 1'b1;
            w_norm_result = {r_sign, r_exp, r_mant[22:0]};
        end else if (w_norm_exp == 8'd0) begin
            w_norm_done   = 1'b1;
            w_norm_result = {r_sign, 31'd0};
        end else if (w_norm_mant[23] || (r_cnt == CW'(MAX_NORM - 1))) begin
            w_norm_done   = 1'b1;
            w_norm_result = {r_sign, w_norm_exp, w_norm_mant[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_big_mant   <= 24'd0;
            r_small_mant <= 24'd0;
            r_mant       <= 24'd0;
            r_exp        <= 8'd0;
            r_sign       <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_cout       <= 1'b0;
            r_cnt        <= '0;
            r_out_data   <= 32'd0;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= {in_b[31] ^ in_sub, in_b[30:0]};
                        r_state    <= S_ALIGN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (w_nan_result || w_a_inf || w_b_inf) begin
                        r_out_data  <= w_nan_result ? 32'h7FC0_0000 : (w_a_inf ? r_a : r_b);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_big_mant   <= w_big_mant;
                        r_small_mant <= w_small_shifted;
                        r_exp        <= w_big_exp;
                        r_sign       <= w_a_ge ? r_a[31] : r_b[31];
                        r_eff_sub    <= r_a[31] ^ r_b[31];
                        r_state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_mant  <= w_sum;
                    r_cout  <= w_cout & ~r_eff_sub;
                    r_cnt   <= '0;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_cout <= 1'b0;
                    r_mant <= w_norm_mant;
                    r_exp  <= w_norm_exp;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_norm_done) begin
                        r_out_data  <= w_norm_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomized + directed bench for fp_add_sequencer, checked against a numeric
// reference model that predicts result and latency for every accepted operation.

module tb_fp_add_sequencer;
    localparam int MAX_NORM = 23;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        busy;

    fp_add_sequencer #(.MAX_NORM(MAX_NORM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          cyc      = 0;
    int          mode     = 2;   // 0 random out_ready, 1 hold low, 2 always high
    bit          head_seen = 0;
    logic [31:0] last_data = 32'd0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on decoded fields.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] r, output int lat);
        int  ea, eb, ma, mb, e_big, e_small, m_big, m_small, d, s, e, n;
        bit  sa, sb, s_big, na, nb, ia, ib, flushed;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        lat = 2;
        if (na || nb || (ia && ib && sa != sb)) begin r = 32'h7FC00000; return; end
        if (ia) begin r = a; return; end
        if (ib) begin r = {sb, b[30:0]}; return; end
        ma = (ea == 0) ? 0 : (int'(a[22:0]) + (1 << 23));
        mb = (eb == 0) ? 0 : (int'(b[22:0]) + (1 << 23));
        if (ea > eb || (ea == eb && ma >= mb)) begin
            e_big = ea; m_big = ma; s_big = sa; e_small = eb; m_small = mb;
        end else begin
            e_big = eb; m_big = mb; s_big = sb; e_small = ea; m_small = ma;
        end
        d = e_big - e_small;
        if (d >= 24) m_small = 0; else m_small = m_small >> d;
        s = (sa == sb) ? m_big + m_small : m_big - m_small;
        e = e_big;
        lat = 4;
        if (sa == sb && s >= (1 << 24)) begin
            s = s >> 1;
            e = e + 1;
            r = (e == 255) ? {s_big, 8'hFF, 23'd0} : {s_big, 8'(e), 23'(s)};
            return;
        end
        if (s == 0) begin r = 32'd0; return; end
        n = 0;
        flushed = 0;
        while (s < (1 << 23) && n < MAX_NORM) begin
            s = s * 2;
            e = e - 1;
            n = n + 1;
            if (e == 0) begin flushed = 1; break; end
        end
        lat = 3 + ((n > 1) ? n : 1);
        r = flushed ? {s_big, 31'd0} : {s_big, 8'(e), 23'(s)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (mode == 2)      out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'b0;
        else                out_ready = ($urandom % 4) != 0;
    end

    // Single compare process: checks handshake sanity and results every cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            head_seen = 0;
        end else begin
            chk("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: got out_valid=1 with data %h, expected no result", out_data);
                end else begin
                    if (!head_seen) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                        head_seen = 1;
                    end
                    chk("out_data", out_data, q[0].data);
                    last_data = out_data;
                    if (out_ready) begin
                        $display("op %0d: a=%h b=%h sub=%0d -> %h (expected %h, lat %0d)",
                                 n_done, q[0].a, q[0].b, q[0].sub, out_data, q[0].data, q[0].lat);
                        void'(q.pop_front());
                        head_seen = 0;
                        n_done++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t t;
                t.a = in_a; t.b = in_b; t.sub = in_sub; t.acc = cyc;
                model(in_a, in_b, in_sub, t.data, t.lat);
                q.push_back(t);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int guard;
        @(posedge clk); #1;
        guard = 0;
        while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!in_ready) begin
            $display("FAIL send_timeout: got in_ready=0 after %0d cycles, expected 1", guard);
            n_checks++; n_fail++;
        end
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && guard < 300) begin @(negedge clk); guard++; end
        if (q.size() != 0 || busy) begin
            $display("FAIL idle_timeout: got %0d pending results, expected 0", q.size());
            n_checks++; n_fail++;
        end
    endtask

    task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] want);
        send(a, b, sub);
        wait_idle();
        chk(nm, last_data, want);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom % 8)
            0: ;
            1: v[30:23] = 8'd0;
            2: v[30:23] = 8'hFF;
            3: v = {v[31], 8'hFF, 23'd0};
            4: v[30:23] = 8'(252 + $urandom % 3);
            default: v[30:23] = 8'(120 + $urandom % 16);
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] r, held, a, b;
        int lat;
        int guard;
        rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data",  out_data, 32'd0);
        chk("reset_busy",      {31'd0, busy}, 32'd0);
        chk("reset_in_ready",  {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Pin the reference model to hand-computed values.
        model(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
        chk("model_1p1", r, 32'h40000000);  chk("model_1p1_lat", 32'(lat), 32'd4);
        model(32'h3F800000, 32'h3F7FFFFF, 1'b1, r, lat);
        chk("model_trunc", r, 32'h34000000); chk("model_trunc_lat", 32'(lat), 32'd26);
        model(32'h7F800000, 32'h7F800000, 1'b1, r, lat);
        chk("model_nan", r, 32'h7FC00000);  chk("model_nan_lat", 32'(lat), 32'd2);

        do_op("lit_1p1",      32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        do_op("lit_1p5_m025", 32'h3FC00000, 32'hBE800000, 1'b0, 32'h3FA00000);
        do_op("lit_1m1",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        do_op("lit_trunc",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000);
        do_op("lit_inf_nan",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
        do_op("lit_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        do_op("lit_neg_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);

        // Backpressure: result held for 10 cycles, then released.
        mode = 1;
        @(negedge clk);
        send(32'h40400000, 32'h3F800000, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        held = 32'h40800000;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_stable", out_data, held);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        mode = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long normalization.
        send(32'h3F800000, 32'h3F7FFFFF, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("midop_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midop_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midop_rst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op("post_rst_1p1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);

        // Randomized traffic with random consumer stalls.
        mode = 0;
        for (int i = 0; i < 300; i++) begin
            a = rand_fp();
            if (($urandom % 4) == 0) b = a ^ 32'($urandom % 16);
            else                     b = rand_fp();
            send(a, b, 1'($urandom));
        end
        mode = 2;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end
endmodule
